// File: rtl/dcache_assoc.sv
// dcache_assoc: parametrised write-back, write-allocate data cache, 1- or 2-way with LRU replacement.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count/wb_count outputs.
module dcache_assoc #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int OFF_W  = 2,
  parameter int IDX_W  = 2,
  parameter int WAYS   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 read,
  input  logic                                 write,
  input  logic [ADDR_W-1:0]                    ADDRESS,
  input  logic [DATA_W-1:0]                    WRITEDATA,
  output logic [DATA_W-1:0]                    READDATA,
  output logic                                 busywait,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [ADDR_W-OFF_W-1:0]              mem_address,
  output logic [(DATA_W<<OFF_W)-1:0]           mem_writedata,
  input  logic [(DATA_W<<OFF_W)-1:0]           mem_readdata,
  input  logic                                 mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                          hit_count,
  output logic [15:0]                          miss_count,
  output logic [15:0]                          wb_count
`endif
);

  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = DATA_W << OFF_W;
  localparam int SETS  = 1 << IDX_W;
  localparam int WORDS = 1 << OFF_W;

  typedef enum logic [1:0] {IDLE, WBACK, FETCH} state_t;

  state_t state, next_state;

  // Storage is always sized for two ways; way 1 simply never validates when WAYS == 1.
  logic [TAG_W-1:0] tag_mem  [2][SETS];
  logic [BLK_W-1:0] data_mem [2][SETS];
  logic [SETS-1:0]  valid    [2];
  logic [SETS-1:0]  dirty    [2];
  logic [SETS-1:0]  lru;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             hit0, hit1, hit, hit_way;
  logic             req, wr_req, serve, miss_start, fill;
  logic             victim;
  logic             vict_way;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;

  logic [WORDS-1:0][DATA_W-1:0] line_words, merged;

  assign tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx = ADDRESS[OFF_W +: IDX_W];
  assign off = ADDRESS[OFF_W-1:0];

  assign hit0    = valid[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1    = (WAYS == 2) && valid[1][idx] && (tag_mem[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;

  assign req        = read || write;
  assign wr_req     = write && !read;
  assign serve      = (state == IDLE) && req && hit;
  assign miss_start = (state == IDLE) && req && !hit;
  assign fill       = (state == FETCH) && !mem_busywait;

  assign line_words = data_mem[hit_way][idx];
  assign READDATA   = hit ? line_words[off] : '0;
  assign busywait   = !reset && req && !((state == IDLE) && hit);

  always_comb begin
    merged      = line_words;
    merged[off] = WRITEDATA;
  end

  // Invalid ways are filled first, way 0 before way 1; otherwise the LRU way is evicted.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid[0][idx])      victim = 1'b0;
      else if (!valid[1][idx]) victim = 1'b1;
      else                     victim = lru[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (req && !hit)
          next_state = (valid[victim][idx] && dirty[victim][idx]) ? WBACK : FETCH;
      end
      WBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_mem[vict_way][miss_idx], miss_idx};
        mem_writedata = data_mem[vict_way][miss_idx];
        if (!mem_busywait) next_state = FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = {miss_tag, miss_idx};
        if (!mem_busywait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The miss context is frozen on leaving IDLE so a dropped request cannot corrupt the refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vict_way <= 1'b0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else if (miss_start) begin
      vict_way <= victim;
      miss_tag <= tag;
      miss_idx <= idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
    end else if (serve) begin
      lru[idx] <= ~hit_way;
      if (wr_req) dirty[hit_way][idx] <= 1'b1;
    end else if (fill) begin
      valid[vict_way][miss_idx] <= 1'b1;
      dirty[vict_way][miss_idx] <= 1'b0;
      lru[miss_idx]             <= ~vict_way;
    end
  end

  always_ff @(posedge clk) begin
    if (serve && wr_req) begin
      data_mem[hit_way][idx] <= merged;
    end else if (fill) begin
      data_mem[vict_way][miss_idx] <= mem_readdata;
      tag_mem[vict_way][miss_idx]  <= miss_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (serve && (hit_count != 16'hFFFF))       hit_count  <= hit_count + 16'd1;
      if (miss_start && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
      if ((state == WBACK) && !mem_busywait && (wb_count != 16'hFFFF))
        wb_count <= wb_count + 16'd1;
    end
  end
`endif

endmodule
